// File: rtl/pc_unit_if.sv
// Control and status bundle between the fetch sequencer and the program counter stage.
// Plain wires only: no storage, no flow control beyond the stall level.
interface pc_unit_if #(
   parameter int WIDTH       = 8,
   parameter int STACK_DEPTH = 4
);
   localparam int DW = $clog2(STACK_DEPTH + 1);

   logic             stall;
   logic             load;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] load_addr;
   logic [WIDTH-1:0] pc;
   logic [DW-1:0]    depth;
   logic             stack_full;
   logic             stack_empty;
   logic             err;

   modport master (
      output stall, load, call, ret, load_addr,
      input  pc, depth, stack_full, stack_empty, err
   );

   modport slave (
      input  stall, load, call, ret, load_addr,
      output pc, depth, stack_full, stack_empty, err
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with increment, branch load and a LIFO return-address stack.
// One-cycle latency on every action; stall holds all state, no other backpressure.
module pc_unit #(
   parameter int WIDTH       = 8,
   parameter int STACK_DEPTH = 4,
   parameter int RESET_ADDR  = 0
) (
   input logic       clk,
   input logic       rst_n,
   pc_unit_if.slave  bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
   logic [DW-1:0]    depth_q, depth_d;
   logic             err_q, err_d;
   logic             push;
   logic [AW-1:0]    top_idx, wr_idx;
   logic             empty, full;
   logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

   assign pc_inc  = pc_q + WIDTH'(1);
   assign empty   = (depth_q == '0);
   assign full    = (depth_q == DW'(STACK_DEPTH));
   assign top_idx = AW'(depth_q - DW'(1));
   assign wr_idx  = AW'(depth_q);

   // Priority chain: stall, ret, call, load, increment.
   always_comb begin
      pc_d    = pc_q;
      depth_d = depth_q;
      err_d   = err_q;
      push    = 1'b0;
      if (!bus.stall) begin
         if (bus.ret) begin
            if (!empty) begin
               pc_d    = stack_mem[top_idx];
               depth_d = depth_q - DW'(1);
            end else begin
               err_d = 1'b1;
            end
         end else if (bus.call) begin
            if (!full) begin
               push    = 1'b1;
               pc_d    = bus.load_addr;
               depth_d = depth_q + DW'(1);
            end else begin
               err_d = 1'b1;
            end
         end else if (bus.load) begin
            pc_d = bus.load_addr;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= WIDTH'(RESET_ADDR);
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   // Entries above depth are invisible, so the array needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[wr_idx] <= pc_inc;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.depth       = depth_q;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.err         = err_q;
endmodule
